// File: rtl/mac_pkg.sv
// mac_pkg: constants and types shared by the MAC receive/transmit blocks.
//   - GMII preamble/SFD byte values
//   - CRC-32 (IEEE 802.3) reflected polynomial, init and residue
//   - mac_rx_state_t: receive framer states
//   - bitrev32: 32-bit bit reversal helper
package mac_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE   = 8'h55;
  localparam logic [7:0]  SFD_BYTE        = 8'hD5;
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  // Good-frame residue written in normal (MSB-first) bit order; the
  // reflected register holds the bit-reverse of this (0xDEBB20E3).
  localparam logic [31:0] CRC32_RESIDUE   = 32'hC704DD7B;
  localparam int          ETH_MIN_LEN     = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_DROP
  } mac_rx_state_t;

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// crc32_d8: combinational byte-wide CRC-32 next-state function.
// Reflected polynomial, data consumed LSB first, no final XOR.
//   crc      in  32 : current CRC register
//   data     in  8  : byte to absorb
//   crc_next out 32 : register after absorbing data
module crc32_d8
  import mac_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);

  always_comb begin
    crc_next = crc;
    for (int b = 0; b < 8; b++) begin
      crc_next = (crc_next >> 1) ^
                 (((crc_next[0] ^ data[b]) != 1'b0) ? CRC32_POLY_REFL : 32'h0);
    end
  end

endmodule

// File: rtl/mac_rx.sv
// mac_rx: GMII receive framer. Strips preamble/SFD, checks FCS and frame
// length, and emits a byte stream with last/error marking plus one-cycle
// status pulses aligned to the last beat. No backpressure.
//
// Build option: MAC_RX_FCS_STRIP_EN -- when defined the 4 FCS bytes are
// not forwarded (5-byte delay line); otherwise FCS is forwarded (1-byte
// delay line).
//
// Ports:
//   clk, reset            : byte clock, synchronous active-high reset
//   RX_DV, RX_ER, RXD     : GMII receive stream
//   m_data/m_valid/m_last : output beat stream, m_error valid on m_last
//   stat_good/crc_err/len_err/rx_er : per-frame status pulses
module mac_rx
  import mac_pkg::*;
#(
  parameter int MAX_LEN = 1518,
  parameter int MIN_LEN = ETH_MIN_LEN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RX_DV,
  input  logic       RX_ER,
  input  logic [7:0] RXD,
  output logic [7:0] m_data,
  output logic       m_valid,
  output logic       m_last,
  output logic       m_error,
  output logic       stat_good,
  output logic       stat_crc_err,
  output logic       stat_len_err,
  output logic       stat_rx_er
);

`ifdef MAC_RX_FCS_STRIP_EN
  localparam int DLY = 5;
`else
  localparam int DLY = 1;
`endif

  mac_rx_state_t         state, state_nx;
  logic [31:0]           crc_q, crc_nx;
  logic [15:0]           len_q;
  logic                  er_q;
  logic [DLY-1:0][7:0]   dline;
  logic                  crc_bad, len_bad, frame_bad, line_full;

  crc32_d8 u_crc (.crc(crc_q), .data(RXD), .crc_next(crc_nx));

  assign crc_bad   = bitrev32(crc_q) != CRC32_RESIDUE;
  assign len_bad   = (len_q < 16'(MIN_LEN)) || (len_q > 16'(MAX_LEN));
  assign frame_bad = crc_bad | len_bad | er_q;
  // Oldest byte in the line is releasable once DLY bytes have entered.
  assign line_full = len_q >= 16'(DLY);

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:
        if (RX_DV) begin
          if (RXD == PREAMBLE_BYTE)  state_nx = ST_PREAMBLE;
          else if (RXD == SFD_BYTE)  state_nx = ST_DATA;
          else                       state_nx = ST_DROP;
        end
      ST_PREAMBLE:
        if (!RX_DV)                  state_nx = ST_IDLE;
        else if (RXD == SFD_BYTE)    state_nx = ST_DATA;
        else if (RXD != PREAMBLE_BYTE) state_nx = ST_DROP;
      ST_DATA:
        if (!RX_DV)                  state_nx = ST_IDLE;
      ST_DROP:
        if (!RX_DV)                  state_nx = ST_IDLE;
      default:                       state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      crc_q        <= CRC32_INIT;
      len_q        <= '0;
      er_q         <= 1'b0;
      dline        <= '0;
      m_data       <= '0;
      m_valid      <= 1'b0;
      m_last       <= 1'b0;
      m_error      <= 1'b0;
      stat_good    <= 1'b0;
      stat_crc_err <= 1'b0;
      stat_len_err <= 1'b0;
      stat_rx_er   <= 1'b0;
    end else begin
      state        <= state_nx;
      m_valid      <= 1'b0;
      m_last       <= 1'b0;
      m_error      <= 1'b0;
      stat_good    <= 1'b0;
      stat_crc_err <= 1'b0;
      stat_len_err <= 1'b0;
      stat_rx_er   <= 1'b0;
      if (state != ST_DATA) begin
        // Re-arm frame accumulators while outside a frame so the first
        // DATA byte always starts from a clean state.
        crc_q <= CRC32_INIT;
        len_q <= '0;
        er_q  <= 1'b0;
      end else if (RX_DV) begin
        crc_q <= crc_nx;
        if (len_q != 16'hFFFF) len_q <= len_q + 16'd1;
        if (RX_ER) er_q <= 1'b1;
        dline[0] <= RXD;
        for (int k = 1; k < DLY; k++) dline[k] <= dline[k-1];
        if (line_full) begin
          m_valid <= 1'b1;
          m_data  <= dline[DLY-1];
        end
      end else begin
        // End of frame: the oldest byte still in the line is the last beat
        // (final FCS byte, or final payload byte when stripping).
        if (line_full) begin
          m_valid <= 1'b1;
          m_last  <= 1'b1;
          m_error <= frame_bad;
          m_data  <= dline[DLY-1];
        end
        stat_good    <= !frame_bad;
        stat_crc_err <= crc_bad;
        stat_len_err <= len_bad;
        stat_rx_er   <= er_q;
      end
    end
  end

endmodule
